fmc150_spi_responder: RTL and testbench

Clocked-logic SPI slave that acts as the device end of the 32-bit FMC150 configuration link. SPICore32 drives this link as master over sclk, sdo, csb and srst. The block oversamples the master's SPI pins in the system clock domain and decodes 32-bit frames into a small register file. For a read command it returns register contents on the next frame. Its uses are as an on-board CDC register model for loopback bring-up, and as the bench responder for the SPI master.

---
 rtl/fmc150_spi_pkg.sv | 27 ++
 rtl/fmc150_spi_sync.sv | 52 +++++
 rtl/fmc150_spi_responder.sv | 160 ++++++++++++++++
 tb/tb_fmc150_spi_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc150_spi_pkg.sv
// Shared constants, frame field helpers and frame-tracking state for the
// FMC150 SPI responder.
package fmc150_spi_pkg;

    localparam int unsigned FRAME_W  = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 28;
    localparam int unsigned BITCNT_W = 6;

    localparam logic [ADDR_W-1:0]   READ_CMD    = 4'hE;
    localparam logic [BITCNT_W-1:0] BITCNT_FULL = 6'd32;
    localparam logic [BITCNT_W-1:0] BITCNT_SAT  = 6'd33;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } frame_state_t;

    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] frame);
        return frame[ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] frame);
        return frame[FRAME_W-1:ADDR_W];
    endfunction

endpackage

// File: rtl/fmc150_spi_sync.sv
// Two-flop synchronizer for the SPI pins plus a registered stage that yields
// sclk/csb edge pulses; all outputs share the same 3-cycle pin latency.
module fmc150_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic csb_in,
    input  logic sdi_in,
    input  logic srst_n_in,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_rise,
    output logic csb_fall,
    output logic csb_level,
    output logic sdi,
    output logic srst_n
);

    // Bit order {srst_n, sdi, csb, sclk}; reset to the idle bus levels so no
    // spurious edge is seen when reset releases.
    localparam logic [3:0] IDLE_LVL = 4'b1010;

    logic [3:0] meta;
    logic [3:0] sync;
    logic [3:0] held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta      <= IDLE_LVL;
            sync      <= IDLE_LVL;
            held      <= IDLE_LVL;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csb_rise  <= 1'b0;
            csb_fall  <= 1'b0;
        end else begin
            meta      <= {srst_n_in, sdi_in, csb_in, sclk_in};
            sync      <= meta;
            held      <= sync;
            sclk_rise <= sync[0] & ~held[0];
            sclk_fall <= ~sync[0] & held[0];
            csb_rise  <= sync[1] & ~held[1];
            csb_fall  <= ~sync[1] & held[1];
        end
    end

    // Levels come from the third stage so they line up with the edge pulses.
    assign csb_level = held[1];
    assign sdi       = held[2];
    assign srst_n    = held[3];

endmodule

// File: rtl/fmc150_spi_responder.sv
// SPI mode-0 slave decoding 32-bit FMC150 frames into a register file.
// Define FMC150_SPI_RESPONDER_READBACK_EN to enable read commands and sdo shift-out.
module fmc150_spi_responder
    import fmc150_spi_pkg::*;
#(
    parameter int unsigned       NREGS   = 14,
    parameter logic [DATA_W-1:0] RST_VAL = 28'h0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              spi_sclk,
    input  logic              spi_csb,
    input  logic              spi_sdi,
    input  logic              spi_srst_n,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int unsigned       LIM_W     = ADDR_W + 1;
    localparam logic [LIM_W-1:0]  NREGS_LIM = LIM_W'(NREGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < NREGS_LIM;
    endfunction

    logic sclk_rise, sclk_fall, csb_rise, csb_fall, csb_level, sdi, srst_n;
    logic srst;

    frame_state_t          state, state_next;
    logic [BITCNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0]    rx;
    logic [ADDR_W-1:0]     rx_addr;
    logic [DATA_W-1:0]     rx_data;
    logic [DATA_W-1:0]     regs [16];
    logic                  frame_end;

    fmc150_spi_sync u_sync (
        .clk       (CLK),
        .rst       (RST),
        .sclk_in   (spi_sclk),
        .csb_in    (spi_csb),
        .sdi_in    (spi_sdi),
        .srst_n_in (spi_srst_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csb_rise  (csb_rise),
        .csb_fall  (csb_fall),
        .csb_level (csb_level),
        .sdi       (sdi),
        .srst_n    (srst_n)
    );

    assign srst      = ~srst_n;
    assign rx_addr   = frame_addr(rx);
    assign rx_data   = frame_data(rx);
    assign frame_end = (state == ST_FRAME) && csb_rise;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A soft reset drops back to idle, so the aborted frame's csb rise is ignored.
    always_comb begin
        state_next = state;
        if (srst) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (csb_fall) state_next = ST_FRAME;
                ST_FRAME: if (csb_rise) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt    <= '0;
            rx         <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            spi_sdo_oe <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) regs[4'(i)] <= RST_VAL;
        end else begin
            wr_valid   <= 1'b0;
            frame_err  <= 1'b0;
            spi_sdo_oe <= ~csb_level;
            if (srst) begin
                bit_cnt <= '0;
                rx      <= '0;
                for (int unsigned i = 0; i < 16; i++) regs[4'(i)] <= RST_VAL;
            end else if (frame_end) begin
                if (bit_cnt == BITCNT_FULL) begin
                    if (in_range(rx_addr)) begin
                        regs[rx_addr] <= rx_data;
                        wr_valid      <= 1'b1;
                        wr_addr       <= rx_addr;
                        wr_data       <= rx_data;
                    end
                end else begin
                    frame_err <= 1'b1;
                    if (err_count != '1) err_count <= err_count + 8'd1;
                end
            end else if ((state == ST_IDLE) && csb_fall) begin
                bit_cnt <= '0;
            end else if ((state == ST_FRAME) && sclk_rise) begin
                rx <= {rx[FRAME_W-2:0], sdi};
                if (bit_cnt != BITCNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range(rd_addr)) rd_data = regs[rd_addr];
    end

`ifdef FMC150_SPI_RESPONDER_READBACK_EN
    logic [FRAME_W-1:0] shadow;
    logic [ADDR_W-1:0]  cmd_idx;
    logic [DATA_W-1:0]  cmd_val;

    assign cmd_idx = rx_data[ADDR_W-1:0];

    always_comb begin
        cmd_val = '0;
        if (in_range(cmd_idx)) cmd_val = regs[cmd_idx];
    end

    // Shadow is loaded only by a read command and cleared by every other frame end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
        end else if (srst) begin
            shadow <= '0;
        end else if (frame_end) begin
            if ((bit_cnt == BITCNT_FULL) && (rx_addr == READ_CMD)) shadow <= {cmd_val, cmd_idx};
            else                                                  shadow <= '0;
        end else if ((state == ST_FRAME) && sclk_fall) begin
            shadow <= {shadow[FRAME_W-2:0], 1'b0};
        end
    end

    assign spi_sdo = shadow[FRAME_W-1];
`else
    assign spi_sdo = 1'b0;
`endif

endmodule

// File: tb/tb_fmc150_spi_responder.sv
// Self-checking bench for fmc150_spi_responder: directed table, random frames
// against a frame-level model, and hand-written soft-reset / reset sequences.
module tb_fmc150_spi_responder;

    localparam int unsigned NREGS_TB = 12;
    localparam logic [27:0] RST_TB   = 28'h5A5A5A5;
    localparam int          H        = 6;
    localparam int          GAP      = 8;
`ifdef FMC150_SPI_RESPONDER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        spi_sclk, spi_csb, spi_sdi, spi_srst_n;
    logic        spi_sdo, spi_sdo_oe, wr_valid, frame_err;
    logic [3:0]  wr_addr, rd_addr;
    logic [27:0] wr_data, rd_data;
    logic [7:0]  err_count;

    fmc150_spi_responder #(.NREGS(NREGS_TB), .RST_VAL(RST_TB)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .spi_sclk   (spi_sclk),
        .spi_csb    (spi_csb),
        .spi_sdi    (spi_sdi),
        .spi_srst_n (spi_srst_n),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;
    int err_seen = 0;

    always @(negedge CLK) begin
        if (wr_valid === 1'b1) wr_seen++;
        if (frame_err === 1'b1) err_seen++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // Frame-level reference model
    logic [27:0] m_regs [16];
    logic [31:0] m_shadow;
    int          m_err;

    function automatic logic [27:0] m_peek(input int idx);
        return (idx < int'(NREGS_TB)) ? m_regs[idx] : 28'h0;
    endfunction

    task automatic m_reset_regs();
        for (int i = 0; i < 16; i++) m_regs[i] = RST_TB;
        m_shadow = '0;
    endtask

    task automatic model_frame(input int nbits, input logic [63:0] word,
                               output logic [31:0] exp_sdo, output int exp_wr, output int exp_err);
        int          a;
        logic [27:0] d;
        logic [31:0] next_shadow;
        exp_sdo     = m_shadow;
        exp_wr      = 0;
        exp_err     = 0;
        next_shadow = '0;
        a = int'(word[3:0]);
        d = word[31:4];
        if (nbits == 32) begin
            if (a < int'(NREGS_TB)) begin
                m_regs[a] = d;
                exp_wr    = 1;
            end else if (RB && a == 14) begin
                next_shadow = {m_peek(int'(d[3:0])), d[3:0]};
            end
        end else begin
            exp_err = 1;
            m_err++;
        end
        m_shadow = next_shadow;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            check($sformatf("%s rd_data[%0d]", tag, a), 64'(rd_data), 64'(m_peek(a)));
        end
    endtask

    task automatic do_frame(input int nbits, input logic [63:0] word, input int srst_at,
                            output logic [31:0] sdo_word, output logic pulse4);
        sdo_word = '0;
        spi_csb  = 1'b0;
        repeat (H) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (i == srst_at) begin
                spi_srst_n = 1'b0;
                repeat (10) @(negedge CLK);
                spi_srst_n = 1'b1;
            end
            spi_sdi = word[nbits-1-i];
            repeat (H) @(negedge CLK);
            spi_sclk = 1'b1;
            if (i < 32) sdo_word = {sdo_word[30:0], spi_sdo};
            repeat (H) @(negedge CLK);
            spi_sclk = 1'b0;
        end
        repeat (H) @(negedge CLK);
        spi_csb = 1'b1;
        repeat (4) @(negedge CLK);
        pulse4 = wr_valid | frame_err;
        repeat (GAP) @(negedge CLK);
    endtask

    typedef struct {
        int          nbits;
        logic [63:0] word;
        int          exp_wr;
        int          exp_err;
        logic [31:0] exp_sdo;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] sdo_word, exp_sdo;
        logic        pulse4;
        int          wr0, er0, ewr, eerr, nbits, addr;
        logic [63:0] w;

        tbl[0]  = '{32, 64'h12345673,     1, 0, 32'h0};
        tbl[1]  = '{32, 64'h0000003E,     0, 0, 32'h0};
        tbl[2]  = '{32, 64'h0000000F,     0, 0, RB ? 32'h12345673 : 32'h0};
        tbl[3]  = '{32, 64'h0000000F,     0, 0, 32'h0};
        tbl[4]  = '{31, 64'h7FFFFFFF,     0, 1, 32'h0};
        tbl[5]  = '{40, 64'hFFFFFFFFF3,   0, 1, 32'h0};
        tbl[6]  = '{32, 64'hABCDEF0F,     0, 0, 32'h0};
        tbl[7]  = '{32, 64'h1111111C,     0, 0, 32'h0};
        tbl[8]  = '{32, 64'h000000BE,     0, 0, 32'h0};
        tbl[9]  = '{32, 64'h0000000F,     0, 0, RB ? 32'h5A5A5A5B : 32'h0};
        tbl[10] = '{32, 64'h000000DE,     0, 0, 32'h0};
        tbl[11] = '{32, 64'h0000000F,     0, 0, RB ? 32'h0000000D : 32'h0};
        tbl[12] = '{32, 64'h0000000F,     0, 0, 32'h0};

        RST = 1'b1; spi_sclk = 1'b0; spi_csb = 1'b1; spi_sdi = 1'b0; spi_srst_n = 1'b1;
        rd_addr = '0;
        m_reset_regs();
        m_err = 0;
        repeat (5) @(negedge CLK);
        check("reset spi_sdo", 64'(spi_sdo), 0);
        check("reset spi_sdo_oe", 64'(spi_sdo_oe), 0);
        check("reset wr_valid", 64'(wr_valid), 0);
        check("reset frame_err", 64'(frame_err), 0);
        check("reset err_count", 64'(err_count), 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check_regs("after reset");

        // Directed table
        for (int r = 0; r < 13; r++) begin
            wr0 = wr_seen; er0 = err_seen;
            model_frame(tbl[r].nbits, tbl[r].word, exp_sdo, ewr, eerr);
            do_frame(tbl[r].nbits, tbl[r].word, -1, sdo_word, pulse4);
            check($sformatf("tbl%0d wr pulses", r), 64'(wr_seen - wr0), 64'(tbl[r].exp_wr));
            check($sformatf("tbl%0d err pulses", r), 64'(err_seen - er0), 64'(tbl[r].exp_err));
            check($sformatf("tbl%0d pulse at +4", r), 64'(pulse4), 64'(tbl[r].exp_wr | tbl[r].exp_err));
            if (tbl[r].nbits >= 32)
                check($sformatf("tbl%0d sdo word", r), 64'(sdo_word), 64'(tbl[r].exp_sdo));
            if (r == 0) begin
                check("tbl0 wr_addr", 64'(wr_addr), 64'h3);
                check("tbl0 wr_data", 64'(wr_data), 64'h1234567);
                rd_addr = 4'd3; #1;
                check("tbl0 rd_data[3]", 64'(rd_data), 64'h1234567);
                check("tbl0 err_count", 64'(err_count), 0);
            end
        end
        check("table err_count", 64'(err_count), 64'd2);
        check_regs("after table");

        // Randomized frames against the model
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 9))
                0:       nbits = 31;
                1:       nbits = 33;
                default: nbits = 32;
            endcase
            addr = ($urandom_range(0, 3) == 0) ? 14 : int'($urandom_range(0, 15));
            w = {32'($urandom), 28'($urandom), 4'(addr)};
            wr0 = wr_seen; er0 = err_seen;
            model_frame(nbits, w, exp_sdo, ewr, eerr);
            do_frame(nbits, w, -1, sdo_word, pulse4);
            check($sformatf("rnd%0d wr pulses", r), 64'(wr_seen - wr0), 64'(ewr));
            check($sformatf("rnd%0d err pulses", r), 64'(err_seen - er0), 64'(eerr));
            if (nbits >= 32) check($sformatf("rnd%0d sdo word", r), 64'(sdo_word), 64'(exp_sdo));
            if (ewr == 1) begin
                check($sformatf("rnd%0d wr_addr", r), 64'(wr_addr), 64'(w[3:0]));
                check($sformatf("rnd%0d wr_data", r), 64'(wr_data), 64'(w[31:4]));
            end
        end
        check_regs("after random");
        check("random err_count", 64'(err_count), 64'((m_err > 255) ? 255 : m_err));

        // Error counter saturation with short frames
        er0 = err_seen;
        for (int r = 0; r < 300; r++) begin
            model_frame(2, 64'h3, exp_sdo, ewr, eerr);
            do_frame(2, 64'h3, -1, sdo_word, pulse4);
        end
        check("saturated err_count", 64'(err_count), 64'((m_err > 255) ? 255 : m_err));
        check("saturation frame_err pulses", 64'(err_seen - er0), 64'd300);
        check_regs("after saturation");

        // Soft reset in the middle of a write frame
        wr0 = wr_seen; er0 = err_seen;
        m_reset_regs();
        do_frame(32, {32'h0, 28'h0ABCDEF, 4'h5}, 16, sdo_word, pulse4);
        check("srst wr pulses", 64'(wr_seen - wr0), 0);
        check("srst err pulses", 64'(err_seen - er0), 0);
        check_regs("after srst");
        wr0 = wr_seen;
        model_frame(32, {32'h0, 28'h7654321, 4'h5}, exp_sdo, ewr, eerr);
        do_frame(32, {32'h0, 28'h7654321, 4'h5}, -1, sdo_word, pulse4);
        check("post-srst wr pulses", 64'(wr_seen - wr0), 1);
        check("post-srst wr_data", 64'(wr_data), 64'h7654321);
        check_regs("post-srst write");

        // Hard reset asserted mid-frame
        spi_csb = 1'b0;
        repeat (H) @(negedge CLK);
        spi_sclk = 1'b1;
        repeat (H) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midframe reset err_count", 64'(err_count), 0);
        check("midframe reset wr_addr", 64'(wr_addr), 0);
        spi_csb = 1'b1; spi_sclk = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_reset_regs();
        m_err = 0;
        check("release spi_sdo_oe", 64'(spi_sdo_oe), 0);
        check("release wr_valid", 64'(wr_valid), 0);
        check("release wr_data", 64'(wr_data), 0);
        check("release frame_err", 64'(frame_err), 0);
        check("release spi_sdo", 64'(spi_sdo), 0);
        check_regs("after midframe reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
